beam_thresh_loader: RTL and testbench

//  Sequences per-beam threshold updates into the beam_alignment trigger block.

---
 rtl/beam_thresh_loader_if.sv | 36 +++
 rtl/beam_thresh_loader.sv | 136 +++++++++++++
 tb/tb_beam_thresh_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/beam_thresh_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : beam_thresh_loader_if
// Description : Config-side write/commit port and beam_alignment load port
//               of the beam threshold loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface beam_thresh_loader_if #(
    parameter int NBEAMS      = 2,
    parameter int THRESH_BITS = 18,
    parameter int ADDR_BITS   = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) ();
    logic [ADDR_BITS-1:0]   wr_addr_i;
    logic [THRESH_BITS-1:0] wr_data_i;
    logic                   wr_valid_i;
    logic                   wr_ready_o;
    logic                   commit_i;
    logic                   err_clr_i;
    logic                   busy_o;
    logic                   done_o;
    logic                   err_o;
    logic [THRESH_BITS-1:0] thresh_o;
    logic [NBEAMS-1:0]      thresh_ce_o;
    logic                   update_o;

    modport slave (
        input  wr_addr_i, wr_data_i, wr_valid_i, commit_i, err_clr_i,
        output wr_ready_o, busy_o, done_o, err_o, thresh_o, thresh_ce_o, update_o
    );

    modport master (
        output wr_addr_i, wr_data_i, wr_valid_i, commit_i, err_clr_i,
        input  wr_ready_o, busy_o, done_o, err_o, thresh_o, thresh_ce_o, update_o
    );
endinterface
`default_nettype wire

// File: rtl/beam_thresh_loader.sv
`default_nettype none
// ============================================================================
// Module      : beam_thresh_loader
// Description : Shadow bank of per-beam thresholds; on commit streams dirty
//               entries one beam per cycle into beam_alignment, then updates.
// Revision    : 1.0 - initial release
// ============================================================================
module beam_thresh_loader #(
    parameter int                     NBEAMS         = 2,
    parameter int                     THRESH_BITS    = 18,
    parameter logic [THRESH_BITS-1:0] DEFAULT_THRESH = 18'h3FFFF,
    parameter int                     ADDR_BITS      = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    beam_thresh_loader_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_UPDATE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic [THRESH_BITS-1:0] shadow_q [NBEAMS];
    logic [THRESH_BITS-1:0] shadow_d [NBEAMS];
    logic [NBEAMS-1:0]      dirty_q, dirty_d;
    logic                   err_q, err_d;
    logic                   wr_ready_q, wr_ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   update_q, update_d;
    logic [THRESH_BITS-1:0] thresh_q, thresh_d;
    logic [NBEAMS-1:0]      ce_q, ce_d;
    logic                   wr_fire;
    logic                   addr_ok;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        dirty_d  = dirty_q;
        err_d    = err_q & ~bus.err_clr_i;
        wr_fire  = bus.wr_valid_i & wr_ready_q;
        addr_ok  = {1'b0, bus.wr_addr_i} < (ADDR_BITS + 1)'(NBEAMS);

        case (state_q)
            S_IDLE: begin
                if (wr_fire) begin
                    if (addr_ok) begin
                        shadow_d[bus.wr_addr_i] = bus.wr_data_i;
                        dirty_d[bus.wr_addr_i]  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // dirty_d already folds in a same-cycle write
                if (bus.commit_i) begin
                    if (|dirty_d) begin
                        state_d = S_LOAD;
                        idx_d   = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (idx_q == ADDR_BITS'(NBEAMS - 1)) begin
                    state_d = S_UPDATE;
                end else begin
                    idx_d = idx_q + ADDR_BITS'(1);
                end
            end
            S_UPDATE: begin
                dirty_d = '0;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered
        wr_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
        update_d   = (state_d == S_UPDATE);
        done_d     = (state_d == S_DONE);
        ce_d       = '0;
        thresh_d   = '0;
        if (state_d == S_LOAD && dirty_d[idx_d]) begin
            ce_d[idx_d] = 1'b1;
            thresh_d    = shadow_d[idx_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            dirty_q    <= '1;
            err_q      <= 1'b0;
            wr_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            update_q   <= 1'b0;
            thresh_q   <= '0;
            ce_q       <= '0;
            for (int b = 0; b < NBEAMS; b++) begin
                shadow_q[b] <= DEFAULT_THRESH;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dirty_q    <= dirty_d;
            err_q      <= err_d;
            wr_ready_q <= wr_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            update_q   <= update_d;
            thresh_q   <= thresh_d;
            ce_q       <= ce_d;
            shadow_q   <= shadow_d;
        end
    end

    assign bus.wr_ready_o  = wr_ready_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.update_o    = update_q;
    assign bus.thresh_o    = thresh_q;
    assign bus.thresh_ce_o = ce_q;

endmodule
`default_nettype wire

// File: tb/tb_beam_thresh_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_beam_thresh_loader
// Description : Scoreboard bench for beam_thresh_loader (three beams).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_beam_thresh_loader;
    localparam int NB = 3;
    localparam int TB = 18;
    localparam int AB = 2;
    localparam logic [TB-1:0] C_DEF = 18'h3FFFF;

    typedef struct {
        logic [NB-1:0] ce;
        logic [TB-1:0] th;
        logic          upd;
        logic          done;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    beam_thresh_loader_if #(.NBEAMS(NB), .THRESH_BITS(TB), .ADDR_BITS(AB)) bus ();

    beam_thresh_loader #(
        .NBEAMS(NB), .THRESH_BITS(TB), .DEFAULT_THRESH(C_DEF), .ADDR_BITS(AB)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    // Reference model: shadow contents, pending beams, error flag, sequence length
    logic [TB-1:0] m_shadow [NB];
    bit   [NB-1:0] m_dirty;
    logic          exp_err;
    int            busy_left;
    rec_t          exp_q[$];
    rec_t          mon_rec;
    bit            mon_en = 1'b0;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit v, input int a, input logic [TB-1:0] d,
                         input bit c, input bit clr, output bit acc);
        rec_t rec;
        bit   newerr;
        acc = 1'b0;
        if (r) begin
            for (int b = 0; b < NB; b++) m_shadow[b] = C_DEF;
            m_dirty   = '1;
            exp_err   = 1'b0;
            busy_left = 0;
            exp_q.delete();
        end else if (busy_left > 0) begin
            busy_left--;
            exp_err = exp_err & ~clr;
        end else begin
            newerr = 1'b0;
            acc    = v;
            if (v) begin
                if (a < NB) begin
                    m_shadow[a] = d;
                    m_dirty[a]  = 1'b1;
                end else begin
                    newerr = 1'b1;
                end
            end
            exp_err = (exp_err & ~clr) | newerr;
            if (c) begin
                if (m_dirty != 0) begin
                    for (int b = 0; b < NB; b++) begin
                        rec.ce = '0; rec.th = '0; rec.upd = 1'b0; rec.done = 1'b0;
                        if (m_dirty[b]) begin
                            rec.ce[b] = 1'b1;
                            rec.th    = m_shadow[b];
                        end
                        exp_q.push_back(rec);
                    end
                    rec.ce = '0; rec.th = '0; rec.upd = 1'b1; rec.done = 1'b0;
                    exp_q.push_back(rec);
                    m_dirty   = '0;
                    busy_left = NB + 2;
                end else begin
                    busy_left = 1;
                end
                rec.ce = '0; rec.th = '0; rec.upd = 1'b0; rec.done = 1'b1;
                exp_q.push_back(rec);
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input int a, input logic [TB-1:0] d,
                        input bit c, input bit clr, output bit acc);
        rst              = r;
        bus.wr_valid_i   = v;
        bus.wr_addr_i    = AB'(a);
        bus.wr_data_i    = d;
        bus.commit_i     = c;
        bus.err_clr_i    = clr;
        @(posedge clk);
        model(r, v, a, d, c, clr, acc);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, '0, 1'b0, 1'b0, acc);
    endtask

    // Monitor: consumes one expected record per busy cycle
    always @(negedge clk) begin
        if (mon_en) begin
            check("err_o", 32'(bus.err_o), 32'(exp_err));
            check("busy_o", 32'(bus.busy_o), 32'(exp_q.size() > 0));
            if (bus.busy_o && exp_q.size() > 0) begin
                mon_rec = exp_q.pop_front();
                check("wr_ready_busy", 32'(bus.wr_ready_o), 32'd0);
                check("thresh_ce_o",   32'(bus.thresh_ce_o), 32'(mon_rec.ce));
                check("thresh_o",      32'(bus.thresh_o), 32'(mon_rec.th));
                check("update_o",      32'(bus.update_o), 32'(mon_rec.upd));
                check("done_o",        32'(bus.done_o), 32'(mon_rec.done));
            end else if (!bus.busy_o) begin
                check("wr_ready_idle", 32'(bus.wr_ready_o), 32'd1);
                check("ce_idle",       32'(bus.thresh_ce_o), 32'd0);
                check("thresh_idle",   32'(bus.thresh_o), 32'd0);
                check("update_idle",   32'(bus.update_o), 32'd0);
                check("done_idle",     32'(bus.done_o), 32'd0);
            end
        end
    end

    initial begin
        bit            acc;
        bit            pv;
        int            pa;
        logic [TB-1:0] pd;
        int            guard;

        step(1'b1, 1'b0, 0, '0, 1'b0, 1'b0, acc);
        mon_en = 1'b1;
        step(1'b1, 1'b0, 0, '0, 1'b0, 1'b0, acc);

        // Defaults loaded on first commit after reset
        step(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, acc);
        idle(NB + 3);

        // Writes then commit
        step(1'b0, 1'b1, 1, 18'h0A, 1'b0, 1'b0, acc);
        step(1'b0, 1'b1, 0, 18'h14, 1'b0, 1'b0, acc);
        step(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, acc);
        idle(NB + 3);

        // Write in the same cycle as commit is included
        step(1'b0, 1'b1, 1, 18'h20, 1'b1, 1'b0, acc);
        idle(NB + 3);

        // Nothing dirty: done only
        step(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, acc);
        idle(3);

        // Write and commit held while busy: write stalls, commit not queued
        step(1'b0, 1'b1, 0, 18'h01, 1'b1, 1'b0, acc);
        guard = 0;
        while (busy_left > 0 && guard < 50) begin
            step(1'b0, 1'b1, 2, 18'h55, 1'b1, 1'b0, acc);
            guard++;
        end
        check("busy_bound", 32'(busy_left), 32'd0);
        step(1'b0, 1'b1, 2, 18'h55, 1'b0, 1'b0, acc);
        check("stalled_write_accept", 32'(acc), 32'd1);
        idle(2);

        // Out-of-range write, clear racing a new error, plain clear
        step(1'b0, 1'b1, 3, 18'h77, 1'b0, 1'b0, acc);
        step(1'b0, 1'b1, 3, 18'h78, 1'b0, 1'b1, acc);
        step(1'b0, 1'b0, 0, '0, 1'b0, 1'b1, acc);
        idle(1);

        // Reset in the middle of a load sequence
        step(1'b0, 1'b1, 1, 18'h2AB, 1'b1, 1'b0, acc);
        idle(2);
        step(1'b1, 1'b0, 0, '0, 1'b0, 1'b0, acc);
        idle(3);

        // Randomized traffic
        pv = 1'b0; pa = 0; pd = '0;
        for (int i = 0; i < 1500; i++) begin
            bit c, clr, r;
            if (!pv && $urandom_range(0, 2) == 0) begin
                pv = 1'b1;
                pa = $urandom_range(0, 3);
                pd = TB'($urandom);
            end
            c   = ($urandom_range(0, 9) == 0);
            clr = ($urandom_range(0, 15) == 0);
            r   = ($urandom_range(0, 199) == 0);
            step(r, pv, pa, pd, c, clr, acc);
            if (acc || r) pv = 1'b0;
        end

        guard = 0;
        while (busy_left > 0 && guard < 20) begin
            idle(1);
            guard++;
        end
        idle(2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
